avk_comparator_debounce: RTL and testbench

AVK_COMPARATOR_DEBOUNCE -- requirements
Module: avk_comparator_debounce

---
 rtl/avk_comparator_debounce_if.sv | 41 ++++
 rtl/avk_comparator_debounce.sv | 154 +++++++++++++++
 tb/tb_avk_comparator_debounce.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avk_comparator_debounce_if.sv
// Purpose: bundles the run enable, the raw comparator inputs and the
// debounced outputs of avk_comparator_debounce into one port.
//   enable          run enable; low freezes outputs and clears debounce counts
//   pos_comparator  raw positive-threshold comparators, active-high
//   neg_comparator  raw negative-threshold comparators, active-low (idle 1)
//   reference       debounced reference state, one bit per channel
//   ref_edge        one-cycle pulse after a change of the matching reference bit
//   conflict        sticky flag: pos and neg debounced-active at the same time
// Modports:
//   master  the side that drives the comparators and watches the results
//   slave   the debounce block itself
// There is no valid/ready handshake on this bus: inputs are raw
// asynchronous levels and outputs are registered levels/pulses.
interface avk_comparator_debounce_if #(
    parameter int CHANNELS = 4
);
    logic                enable;
    logic [CHANNELS-1:0] pos_comparator;
    logic [CHANNELS-1:0] neg_comparator;
    logic [CHANNELS-1:0] reference;
    logic [CHANNELS-1:0] ref_edge;
    logic [CHANNELS-1:0] conflict;

    modport master (
        output enable,
        output pos_comparator,
        output neg_comparator,
        input  reference,
        input  ref_edge,
        input  conflict
    );

    modport slave (
        input  enable,
        input  pos_comparator,
        input  neg_comparator,
        output reference,
        output ref_edge,
        output conflict
    );
endinterface

// File: rtl/avk_comparator_debounce.sv
// Purpose: per-channel debounce of a positive/negative comparator pair and
// derivation of a reference state from the debounced edges.
//   MODE 0: pos rise sets reference, neg rise clears it.
//   MODE 1: pos rise toggles reference; neg only feeds conflict detection.
// Every raw bit goes through a 2-flop synchroniser, then its own debounce
// counter; the debounced level is accepted after DEBOUNCE_CYCLES
// consecutive disagreeing cycles. Reference updates one edge later, so a
// clean input change reaches reference after DEBOUNCE_CYCLES+3 edges.
// Ports:
//   clock  system clock, rising-edge active
//   reset  asynchronous active-low reset (release synchronised internally)
//   bus    avk_comparator_debounce_if slave modport (enable, comparators,
//          reference, ref_edge, conflict)
module avk_comparator_debounce #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4000,
    parameter int MODE            = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    avk_comparator_debounce_if.slave bus
);
    // Debounced bits are handled as one vector: pos in the low half,
    // neg in the high half.
    localparam int            N          = 2 * CHANNELS;
    localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0]  IDLE       = {{CHANNELS{1'b1}}, {CHANNELS{1'b0}}};

    logic [1:0]          rst_sync;
    logic                run_ok;
    logic [N-1:0]        raw;
    logic [N-1:0]        sync_1;
    logic [N-1:0]        sync_2;
    logic [N-1:0]        debounced;
    logic [CW-1:0]       count [N];

    logic [CHANNELS-1:0] pos_act;
    logic [CHANNELS-1:0] neg_act;
    logic [CHANNELS-1:0] pos_act_d;
    logic [CHANNELS-1:0] neg_act_d;
    logic [CHANNELS-1:0] pos_rise;
    logic [CHANNELS-1:0] neg_rise;
    logic [CHANNELS-1:0] both_act;
    logic [CHANNELS-1:0] ref_next;
    logic [CHANNELS-1:0] reference_q;
    logic [CHANNELS-1:0] ref_edge_q;
    logic [CHANNELS-1:0] conflict_q;

    // Reset asserts asynchronously everywhere, but the core only starts
    // running two edges after release, so nothing moves on the first edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_ok = rst_sync[1];
    assign raw    = {bus.neg_comparator, bus.pos_comparator};

    // Synchronisers and debounce counters. The synchronisers run even with
    // enable low; the counters are held at zero so the debounced levels
    // cannot move and debouncing restarts from scratch on enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1    <= IDLE;
            sync_2    <= IDLE;
            debounced <= IDLE;
            for (int i = 0; i < N; i++) begin
                count[i] <= '0;
            end
        end else if (!run_ok) begin
            sync_1    <= IDLE;
            sync_2    <= IDLE;
            debounced <= IDLE;
            for (int i = 0; i < N; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            for (int i = 0; i < N; i++) begin
                if (!bus.enable || (sync_2[i] == debounced[i])) begin
                    // Agreement (or a bounce back) discards any partial count.
                    count[i] <= '0;
                end else if (count[i] == LAST_COUNT) begin
                    count[i]     <= '0;
                    debounced[i] <= sync_2[i];
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
        end
    end

    // Both activity signals are active-high here; neg is inverted.
    assign pos_act  = debounced[CHANNELS-1:0];
    assign neg_act  = ~debounced[N-1:CHANNELS];
    assign pos_rise = pos_act & ~pos_act_d;
    assign neg_rise = neg_act & ~neg_act_d;
    assign both_act = pos_act & neg_act;

    always_comb begin
        ref_next = reference_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!both_act[c]) begin
                if (MODE == 0) begin
                    if (pos_rise[c] && !neg_act[c]) begin
                        ref_next[c] = 1'b1;
                    end else if (neg_rise[c] && !pos_act[c]) begin
                        ref_next[c] = 1'b0;
                    end
                end else begin
                    if (pos_rise[c] && !neg_act[c]) begin
                        ref_next[c] = ~reference_q[c];
                    end
                end
            end
        end
    end

    // Output stage. The delayed activity copies are frozen with enable low
    // so a debounced rise that lands just before a freeze is still acted on
    // once the block runs again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos_act_d   <= '0;
            neg_act_d   <= '0;
            reference_q <= '0;
            ref_edge_q  <= '0;
            conflict_q  <= '0;
        end else if (!run_ok) begin
            pos_act_d   <= '0;
            neg_act_d   <= '0;
            reference_q <= '0;
            ref_edge_q  <= '0;
            conflict_q  <= '0;
        end else if (bus.enable) begin
            pos_act_d   <= pos_act;
            neg_act_d   <= neg_act;
            reference_q <= ref_next;
            ref_edge_q  <= ref_next ^ reference_q;
            conflict_q  <= conflict_q | both_act;
        end else begin
            ref_edge_q  <= '0;
        end
    end

    assign bus.reference = reference_q;
    assign bus.ref_edge  = ref_edge_q;
    assign bus.conflict  = conflict_q;
endmodule

// File: tb/tb_avk_comparator_debounce.sv
// Bench for avk_comparator_debounce with CHANNELS=2, DEBOUNCE_CYCLES=8.
// Two instances (MODE 0 and MODE 1) see identical stimulus; a behavioural
// model predicts both. Inputs change on the falling edge, outputs are
// compared on the falling edge after each rising edge.
module tb_avk_comparator_debounce;
    localparam int C = 2;
    localparam int D = 8;
    localparam int N = 2 * C;
    localparam logic [N-1:0] IDLE = {{C{1'b1}}, {C{1'b0}}};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic         en_in;
    logic [C-1:0] pos_in;
    logic [C-1:0] neg_in;

    avk_comparator_debounce_if #(.CHANNELS(C)) if0 ();
    avk_comparator_debounce_if #(.CHANNELS(C)) if1 ();

    assign if0.enable         = en_in;
    assign if0.pos_comparator = pos_in;
    assign if0.neg_comparator = neg_in;
    assign if1.enable         = en_in;
    assign if1.pos_comparator = pos_in;
    assign if1.neg_comparator = neg_in;

    avk_comparator_debounce #(.CHANNELS(C), .DEBOUNCE_CYCLES(D), .MODE(0)) u_dut_m0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    avk_comparator_debounce #(.CHANNELS(C), .DEBOUNCE_CYCLES(D), .MODE(1)) u_dut_m1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Levels enter a two-deep delay line; a level is accepted once it has
    // disagreed with the accepted level for D enabled edges in a row.
    // Reference reacts one edge later to rises of the accepted activity.
    logic [N-1:0] delay_q [$];
    int           disagree [N];
    logic [N-1:0] accepted;
    logic [C-1:0] seen_pos, seen_neg;
    logic [C-1:0] m_ref0, m_ref1, m_edge0, m_edge1, m_conf;
    int           rel_cnt;

    task automatic model_reset();
        delay_q = {IDLE, IDLE};
        for (int b = 0; b < N; b++) disagree[b] = 0;
        accepted = IDLE;
        seen_pos = '0;
        seen_neg = '0;
        m_ref0   = '0;
        m_ref1   = '0;
        m_edge0  = '0;
        m_edge1  = '0;
        m_conf   = '0;
        rel_cnt  = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        logic [C-1:0] pa, na;
        logic n0, n1, pr, nr;
        if (!reset) return;
        if (rel_cnt < 2) begin
            rel_cnt++;
            return;
        end
        pa = accepted[C-1:0];
        na = ~accepted[N-1:C];
        if (en_in) begin
            for (int c = 0; c < C; c++) begin
                pr = pa[c] && !seen_pos[c];
                nr = na[c] && !seen_neg[c];
                n0 = m_ref0[c];
                n1 = m_ref1[c];
                if (pa[c] && na[c]) begin
                    m_conf[c] = 1'b1;
                end else begin
                    if (pr) n0 = 1'b1;
                    else if (nr) n0 = 1'b0;
                    if (pr) n1 = !n1;
                end
                m_edge0[c] = (n0 != m_ref0[c]);
                m_edge1[c] = (n1 != m_ref1[c]);
                m_ref0[c]  = n0;
                m_ref1[c]  = n1;
            end
            seen_pos = pa;
            seen_neg = na;
        end else begin
            m_edge0 = '0;
            m_edge1 = '0;
        end
        s = delay_q.pop_front();
        delay_q.push_back({neg_in, pos_in});
        for (int b = 0; b < N; b++) begin
            if (en_in && (s[b] != accepted[b])) begin
                disagree[b]++;
                if (disagree[b] == D) begin
                    accepted[b] = s[b];
                    disagree[b] = 0;
                end
            end else begin
                disagree[b] = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("ref_m0",  32'(if0.reference), 32'(m_ref0));
        check("edge_m0", 32'(if0.ref_edge),  32'(m_edge0));
        check("conf_m0", 32'(if0.conflict),  32'(m_conf));
        check("ref_m1",  32'(if1.reference), 32'(m_ref1));
        check("edge_m1", 32'(if1.ref_edge),  32'(m_edge1));
        check("conf_m1", 32'(if1.conflict),  32'(m_conf));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        check("rst_ref_m0",  32'(if0.reference), 32'd0);
        check("rst_edge_m0", 32'(if0.ref_edge),  32'd0);
        check("rst_conf_m0", 32'(if0.conflict),  32'd0);
        check("rst_ref_m1",  32'(if1.reference), 32'd0);
        check("rst_conf_m1", 32'(if1.conflict),  32'd0);
        model_reset();
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        en_in  = 1'b1;
        pos_in = '0;
        neg_in = '1;
    endtask

    task automatic fresh();
        idle_inputs();
        do_reset(3);
        repeat (4) tick();
    endtask

    // ---------------- stimulus ----------------
    int bounce_len [4] = '{3, 5, 2, 7};
    int n_pulse;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;

        // Set/clear with exact latency.
        fresh();
        pos_in[0] = 1'b1;
        repeat (D + 2) tick();
        check("s1_ref_before", 32'(if0.reference[0]), 32'd0);
        tick();
        check("s1_ref_set", 32'(if0.reference[0]), 32'd1);
        check("s1_edge",    32'(if0.ref_edge[0]),  32'd1);
        tick();
        check("s1_edge_once", 32'(if0.ref_edge[0]), 32'd0);
        repeat (8) tick();
        pos_in[0] = 1'b0;
        repeat (15) tick();
        check("s1_ref_kept", 32'(if0.reference[0]), 32'd1);
        neg_in[0] = 1'b0;
        repeat (D + 2) tick();
        check("s1_clr_before", 32'(if0.reference[0]), 32'd1);
        tick();
        check("s1_ref_clr", 32'(if0.reference[0]), 32'd0);
        repeat (10) tick();
        neg_in[0] = 1'b1;
        repeat (15) tick();

        // Bounce rejection on channel 1.
        fresh();
        for (int k = 0; k < 4; k++) begin
            pos_in[1] = (k % 2 == 0);
            repeat (bounce_len[k]) begin
                tick();
                check("s2_no_edge", 32'(if0.ref_edge[1]), 32'd0);
            end
        end
        pos_in[1] = 1'b1;
        repeat (D + 2) tick();
        check("s2_ref_before", 32'(if0.reference[1]), 32'd0);
        tick();
        check("s2_ref_set", 32'(if0.reference[1]), 32'd1);
        repeat (5) tick();

        // Conflict on channel 0.
        fresh();
        pos_in[0] = 1'b1;
        neg_in[0] = 1'b0;
        repeat (20) tick();
        check("s3_conf",     32'(if0.conflict[0]),  32'd1);
        check("s3_ref_hold", 32'(if0.reference[0]), 32'd0);
        idle_inputs();
        repeat (20) tick();
        check("s3_conf_sticky", 32'(if0.conflict[0]),  32'd1);
        check("s3_ref_still",   32'(if0.reference[0]), 32'd0);

        // Toggle mode: three clean pulses give 1,0,1.
        fresh();
        n_pulse = 0;
        for (int k = 0; k < 3; k++) begin
            pos_in[0] = 1'b1;
            repeat (12) begin
                tick();
                if (if1.ref_edge[0]) n_pulse++;
            end
            pos_in[0] = 1'b0;
            repeat (12) begin
                tick();
                if (if1.ref_edge[0]) n_pulse++;
            end
            check("s4_toggle_ref", 32'(if1.reference[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("s4_pulse_count", 32'(n_pulse), 32'd3);

        // Reset mid-count on channel 1 with the input held high.
        fresh();
        pos_in[1] = 1'b1;
        repeat (7) tick();
        do_reset(4);
        repeat (D + 4) tick();
        check("s5_ref_before", 32'(if0.reference[1]), 32'd0);
        tick();
        check("s5_ref_set", 32'(if0.reference[1]), 32'd1);

        // Enable held low across a pos change.
        fresh();
        en_in     = 1'b0;
        pos_in[0] = 1'b1;
        repeat (20) tick();
        check("s6_ref_frozen", 32'(if0.reference[0]), 32'd0);
        en_in = 1'b1;
        repeat (D) tick();
        check("s6_ref_before", 32'(if0.reference[0]), 32'd0);
        tick();
        check("s6_ref_set", 32'(if0.reference[0]), 32'd1);

        // Random traffic with enable gaps and occasional resets.
        fresh();
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < C; b++) begin
                if ($urandom_range(0, 11) == 0) pos_in[b] = ~pos_in[b];
                if ($urandom_range(0, 11) == 0) neg_in[b] = ~neg_in[b];
            end
            if (en_in) begin
                if ($urandom_range(0, 149) == 0) en_in = 1'b0;
            end else if ($urandom_range(0, 14) == 0) begin
                en_in = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) do_reset(int'($urandom_range(1, 3)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
